// File: rtl/calc_pkg.sv
// calc_pkg: shared operand width, arbiter FSM encoding and result error codes.
package calc_pkg;
  localparam int W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_DZ = 2'b01;
  localparam logic [1:0] ERR_TO = 2'b10;
endpackage

// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if: requester, divider and result signals of the shared divider arbiter.
interface div_share_arbiter_if;
  import calc_pkg::*;
  logic [1:0] req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0] grant;
  logic busy;
  logic [W-1:0] div_a, div_b;
  logic div_start;
  logic div_done;
  logic [7:0] div_q;
  logic res_valid;
  logic res_id;
  logic [7:0] res_q;
  logic [1:0] res_err;
  modport slave (input req, a0, b0, a1, b1, div_done, div_q,
                 output grant, busy, div_a, div_b, div_start, res_valid, res_id, res_q, res_err);
  modport master (output req, a0, b0, a1, b1, div_done, div_q,
                  input grant, busy, div_a, div_b, div_start, res_valid, res_id, res_q, res_err);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win
);
  always_comb o_win = (&i_req) ? (i_last ? 2'b01 : 2'b10) : (i_req[0] ? 2'b01 : {i_req[1], 1'b0});
endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one signed divider between two requesters with timeout abort.
// Define DIV_ZERO_TRAP_EN to answer zero divisors with error 01 without using the divider.
module div_share_arbiter
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  div_share_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t r_state, w_next;
  logic r_ptr, r_id, r_res_id, w_id, w_trap, w_cap;
  logic [1:0] w_win, r_err;
  logic [W-1:0] r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_q;
  // r_ptr is the preferred requester; the arbiter wants the last-served one
  rr_arb2 u_rr (.i_req(bus.req), .i_last(~r_ptr), .o_win(w_win));
  assign w_id  = w_win[1];
  assign w_cap = r_state == IDLE && |bus.req;
`ifdef DIV_ZERO_TRAP_EN
  assign w_trap = r_b == '0;
`else
  assign w_trap = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |bus.req ? ISSUE : IDLE;
      ISSUE:   w_next = w_trap ? RESULT : WAIT;
      WAIT:    w_next = (bus.div_done || r_cnt == CW'(TIMEOUT)) ? RESULT : WAIT;
      default: w_next = IDLE;
    endcase
    bus.grant     = (rst && r_state == IDLE) ? w_win : 2'b00;
    bus.div_start = rst && r_state == ISSUE && !w_trap;
    bus.res_valid = rst && r_state == RESULT;
    bus.busy      = rst && r_state != IDLE;
    bus.div_a     = r_a;
    bus.div_b     = r_b;
    bus.res_id    = r_res_id;
    bus.res_q     = r_q;
    bus.res_err   = r_err;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_id     <= 1'b0;
      r_res_id <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_err    <= ERR_OK;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (w_cap) begin
        r_id  <= w_id;
        r_ptr <= ~w_id;
        r_a   <= w_id ? bus.a1 : bus.a0;
        r_b   <= w_id ? bus.b1 : bus.b0;
      end
      if (r_state == ISSUE && w_trap) begin
        r_q      <= 8'hFF;
        r_err    <= ERR_DZ;
        r_res_id <= r_id;
      end
      if (r_state == WAIT && (bus.div_done || r_cnt == CW'(TIMEOUT))) begin
        r_q      <= bus.div_done ? bus.div_q : 8'h00;
        r_err    <= bus.div_done ? ERR_OK : ERR_TO;
        r_res_id <= r_id;
      end
    end
  end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed checks of arbitration, divider handshake, timeout and reset.
module tb_div_share_arbiter;
  import calc_pkg::*;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  div_share_arbiter_if bus ();
  div_share_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // divider stand-in: done arrives lat cycles into WAIT, caller is left in RESULT
  task automatic finish_op(input logic [7:0] q, input int lat);
    repeat (lat) tick();
    bus.div_done = 1'b1;
    bus.div_q = q;
    tick();
    bus.div_done = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    bus.req = 2'b11;
    tick();
    tick();
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_grant got=%b exp=00", bus.grant); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if ({bus.div_start, bus.res_valid, bus.res_id, bus.res_err, bus.res_q, bus.div_a, bus.div_b} !== 22'h0) begin
      fails++; $display("FAIL reset_outputs got=%h exp=0", {bus.div_start, bus.res_valid, bus.res_id, bus.res_err, bus.res_q, bus.div_a, bus.div_b});
    end
    bus.req = 2'b00;
    rst = 1'b1;
    tick();
  endtask
  task automatic test_single;
    bus.a0 = 4'd7; bus.b0 = 4'd2; bus.req = 2'b01;
    #1;
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL single_grant got=%b exp=01", bus.grant); end
    tick();
    bus.req = 2'b00;
    tests++; if (bus.div_start !== 1'b1) begin fails++; $display("FAIL single_start got=%b exp=1", bus.div_start); end
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL single_grant_pulse got=%b exp=00", bus.grant); end
    tests++; if ({bus.div_a, bus.div_b} !== 8'h72) begin fails++; $display("FAIL single_operands got=%h exp=72", {bus.div_a, bus.div_b}); end
    tick();
    tests++; if (bus.div_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse got=%b exp=0", bus.div_start); end
    bus.div_done = 1'b1; bus.div_q = 8'h03;
    tick();
    bus.div_done = 1'b0;
    tests++; if ({bus.res_valid, bus.res_id, bus.res_err, bus.res_q} !== 12'h803) begin
      fails++; $display("FAIL single_result got=%h exp=803", {bus.res_valid, bus.res_id, bus.res_err, bus.res_q});
    end
    tick();
    tests++; if ({bus.res_valid, bus.busy, bus.res_q} !== 10'h003) begin fails++; $display("FAIL single_idle_hold got=%h exp=003", {bus.res_valid, bus.busy, bus.res_q}); end
  endtask
  task automatic test_contention;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.a0 = 4'd1; bus.b0 = 4'd1; bus.a1 = 4'b1000; bus.b1 = 4'd3; bus.req = 2'b11;
    #1;
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL cont_first got=%b exp=01", bus.grant); end
    tick();
    finish_op(8'h01, 1);
    tests++; if ({bus.res_valid, bus.res_id, bus.grant} !== 4'b1000) begin fails++; $display("FAIL cont_result0 got=%b exp=1000", {bus.res_valid, bus.res_id, bus.grant}); end
    tick();
    tests++; if (bus.grant !== 2'b10) begin fails++; $display("FAIL cont_second got=%b exp=10", bus.grant); end
    tick();
    tests++; if ({bus.div_a, bus.div_b} !== 8'h83) begin fails++; $display("FAIL cont_neg8_fwd got=%h exp=83", {bus.div_a, bus.div_b}); end
    finish_op(8'hFE, 1);
    tests++; if ({bus.res_id, bus.res_q} !== 9'h1FE) begin fails++; $display("FAIL cont_result1 got=%h exp=1fe", {bus.res_id, bus.res_q}); end
    tick();
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL cont_third got=%b exp=01", bus.grant); end
    tick();
    bus.req = 2'b00;
    finish_op(8'h01, 1);
    tick();
  endtask
  task automatic test_timeout;
    int n;
    bus.a0 = 4'd5; bus.b0 = 4'd1; bus.req = 2'b01;
    #1;
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL to_grant got=%b exp=01", bus.grant); end
    tick();
    bus.req = 2'b00;
    tests++; if (bus.div_start !== 1'b1) begin fails++; $display("FAIL to_start got=%b exp=1", bus.div_start); end
    n = 0;
    while (!bus.res_valid && n < 40) begin tick(); n++; end
    tests++; if (n !== TO + 2) begin fails++; $display("FAIL to_latency got=%0d exp=%0d", n, TO + 2); end
    tests++; if ({bus.res_err, bus.res_q} !== 10'h200) begin fails++; $display("FAIL to_result got=%h exp=200", {bus.res_err, bus.res_q}); end
    tick();
    bus.a1 = 4'd6; bus.b1 = 4'd3; bus.req = 2'b10;
    #1;
    tests++; if (bus.grant !== 2'b10) begin fails++; $display("FAIL to_next_grant got=%b exp=10", bus.grant); end
    tick();
    bus.req = 2'b00;
    finish_op(8'h02, 2);
    tests++; if ({bus.res_valid, bus.res_id, bus.res_err, bus.res_q} !== 12'hC02) begin
      fails++; $display("FAIL to_next_result got=%h exp=c02", {bus.res_valid, bus.res_id, bus.res_err, bus.res_q});
    end
    tick();
  endtask
  task automatic test_zero_div;
    bus.a1 = 4'd3; bus.b1 = 4'd0; bus.req = 2'b10;
    #1;
    tests++; if (bus.grant !== 2'b10) begin fails++; $display("FAIL dz_grant got=%b exp=10", bus.grant); end
    tick();
    bus.req = 2'b00;
`ifdef DIV_ZERO_TRAP_EN
    tests++; if (bus.div_start !== 1'b0) begin fails++; $display("FAIL dz_no_start got=%b exp=0", bus.div_start); end
    tick();
    tests++; if ({bus.res_valid, bus.res_id, bus.res_err, bus.res_q} !== 12'hDFF) begin
      fails++; $display("FAIL dz_result got=%h exp=dff", {bus.res_valid, bus.res_id, bus.res_err, bus.res_q});
    end
`else
    tests++; if (bus.div_start !== 1'b1) begin fails++; $display("FAIL dz_start got=%b exp=1", bus.div_start); end
    finish_op(8'h00, 1);
    tests++; if ({bus.res_valid, bus.res_err} !== 3'b100) begin fails++; $display("FAIL dz_err got=%b exp=100", {bus.res_valid, bus.res_err}); end
`endif
    tick();
  endtask
  task automatic test_reset_wait;
    bus.a0 = 4'd4; bus.b0 = 4'd2; bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    tick();
    tick();
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rw_busy_wait got=%b exp=1", bus.busy); end
    rst = 1'b0;
    #1;
    tests++; if ({bus.busy, bus.div_start, bus.res_valid} !== 3'b000) begin fails++; $display("FAIL rw_gated got=%b exp=000", {bus.busy, bus.div_start, bus.res_valid}); end
    tick();
    rst = 1'b1;
    bus.div_done = 1'b1; bus.div_q = 8'h02;
    tick();
    bus.div_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({bus.res_valid, bus.busy} !== 2'b00) begin fails++; $display("FAIL rw_late_done got=%b exp=00", {bus.res_valid, bus.busy}); end
      tick();
    end
    tests++; if ({bus.grant, bus.busy, bus.div_start, bus.res_valid, bus.res_id, bus.res_err, bus.res_q, bus.div_a, bus.div_b} !== 24'h0) begin
      fails++; $display("FAIL rw_outputs got=%h exp=0", {bus.grant, bus.busy, bus.div_start, bus.res_valid, bus.res_id, bus.res_err, bus.res_q, bus.div_a, bus.div_b});
    end
  endtask
  task automatic test_stability;
    bus.a0 = 4'hD; bus.b0 = 4'd2; bus.req = 2'b01;
    #1;
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL stab_grant got=%b exp=01", bus.grant); end
    tick();
    bus.req = 2'b00; bus.a0 = 4'd1; bus.b0 = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({bus.div_a, bus.div_b} !== 8'hD2) begin fails++; $display("FAIL stab_hold got=%h exp=d2", {bus.div_a, bus.div_b}); end
      tick();
    end
    bus.div_done = 1'b1; bus.div_q = 8'hFF;
    tick();
    bus.div_done = 1'b0;
    tests++; if ({bus.res_valid, bus.res_q, bus.div_a, bus.div_b} !== 17'h1FFD2) begin
      fails++; $display("FAIL stab_result got=%h exp=1ffd2", {bus.res_valid, bus.res_q, bus.div_a, bus.div_b});
    end
    tick();
  endtask
  initial begin
    rst = 1'b0;
    bus.req = 2'b00; bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.div_done = 1'b0; bus.div_q = '0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_zero_div();
    test_reset_wait();
    test_stability();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
